alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the team's single registered ALU (the `dut` block: clk, rst, sel[1:0], a[15:0], b[15:0] in; r[31:0] out) between N_REQ requesters.
- Each requester submits one operation with a valid/ready handshake. The arbiter grants round-robin, drives the ALU operands, waits the ALU latency, then captures r and returns it on that requester's response channel.
- Sits between client blocks and the ALU instance; the ALU is never driven directly by clients.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ALU_LAT, 1, cycles from operands stable at the ALU inputs to r valid.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester request accept, one-hot or zero.
- req_sel  input  2*N_REQ  op select; requester i occupies bits [2i+1:2i].
- req_a  input  16*N_REQ  operand a; requester i occupies bits [16i+15:16i].
- req_b  input  16*N_REQ  operand b; same packing as req_a.
- rsp_valid  output  N_REQ  per-requester response valid, one-hot or zero.
- rsp_ready  input  N_REQ  per-requester response accept.
- rsp_data  output  32  result, shared by all requesters; qualified by rsp_valid.
- alu_sel  output  2  to ALU sel.
- alu_a  output  16  to ALU a.
- alu_b  output  16  to ALU b.
- alu_r  input  32  from ALU r.

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE; round-robin pointer goes to 0; wait counter is cleared.
  - req_ready=0, rsp_valid=0, rsp_data=0, alu_sel=0, alu_a=0, alu_b=0.
  - An in-flight operation is dropped with no response.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from the pointer upward and wrapping modulo N_REQ.
  - req_ready[g]=1 combinationally in this cycle; all other req_ready bits are 0.
  - If no req_valid is set, req_ready=0 and the state stays IDLE.
  - On the handshake edge: latch sel/a/b of requester g and g itself, then go to ISSUE.
- ISSUE:
  - alu_sel/alu_a/alu_b are registered from the latched operands and stay held until the next grant.
  - Wait counter loads ALU_LAT; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 0, capture alu_r into rsp_data and go to RESP.
  - Latency from operands stable to capture is exactly ALU_LAT cycles.
- RESP:
  - rsp_valid[g]=1 and rsp_data is held stable until rsp_ready[g]=1.
  - On the handshake edge: rsp_valid clears, pointer becomes (g+1) mod N_REQ, go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Throughput and ordering:
  - Minimum ALU_LAT+3 cycles per operation, request handshake to response handshake inclusive.
  - Only one operation is outstanding at a time.
- Request side constraints:
  - req_ready is 0 in every state except IDLE.
  - A requester must hold valid and data stable until ready; dropping valid before ready is legal and withdraws the request.
  - Requests arriving during ISSUE/WAIT/RESP are not lost; they are served later under round-robin.
- Width: sel, a and b pass through unmodified; r is captured as 32-bit with no sign handling.
- Simultaneous events:
  - rsp_ready asserted in the same cycle as new req_valid: the response completes first, and the new grant is evaluated the following cycle in IDLE with the updated pointer.
  - All N_REQ requesting simultaneously: each is served exactly once before any is served twice.

Test Plan:
- Reset, then a single request: req 0 with sel=0, a=10, b=20.
  - Expected: req_ready[0] high in the valid cycle; alu_a=10 and alu_b=20 one cycle later.
  - Expected: rsp_valid[0] rises exactly ALU_LAT+2 cycles after the handshake edge, with rsp_data equal to ALU r for (sel=0, 10, 20).
- Round-robin fairness: all 4 requesters valid continuously, each with a distinct sel=i, a=10*i, b=20.
  - Expected grant order 0,1,2,3,0; each rsp_data matches the ALU result for its own operands.
- Response backpressure: hold rsp_ready[2]=0 for 5 cycles.
  - Expected: rsp_valid[2] and rsp_data stay stable; req_ready stays 0 throughout.
  - Expected: next grant appears one cycle after rsp_ready[2]=1.
- Pointer wrap: only req 3 valid, then req 0 and req 3 both valid.
  - Expected: req 3 first, then req 0; a second req 3 only after req 0.
- Reset mid-operation: assert rst in the WAIT state.
  - Expected: all outputs 0 immediately; no rsp_valid is ever raised for the dropped operation.
  - Expected: after release, a new request from req 0 is granted with the pointer at 0.
- Signed result: sel=1, a=10, b=20 on requester 1.
  - Expected: rsp_data is bit-identical to ALU r; the bench checks the $signed value against its ALU model.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of the ALU share arbiter: per-requester request and
// response handshakes plus the shared response data word.
interface alu_share_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ-1:0]      req_ready;
   logic [2*N_REQ-1:0]    req_sel;
   logic [16*N_REQ-1:0]   req_a;
   logic [16*N_REQ-1:0]   req_b;
   logic [N_REQ-1:0]      rsp_valid;
   logic [N_REQ-1:0]      rsp_ready;
   logic [31:0]           rsp_data;

   // Client side: issues operations and accepts results.
   modport master (
      output req_valid, req_sel, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   // Arbiter side: accepts operations and returns results.
   modport slave (
      input  req_valid, req_sel, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between N_REQ requesters.
// One operation is in flight at a time: grant, issue operands, wait for the
// ALU latency, capture the result and return it to the granted requester.
module alu_share_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   alu_share_arbiter_if.slave  bus,
   output logic [1:0]          alu_sel,
   output logic [15:0]         alu_a,
   output logic [15:0]         alu_b,
   input  logic [31:0]         alu_r
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   gnt;
   logic [CW-1:0]   cnt;
   logic [1:0]      lat_sel;
   logic [15:0]     lat_a;
   logic [15:0]     lat_b;

   logic            grant_found;
   logic [PW-1:0]   grant_idx;
   logic [PW:0]     cand;

   // Round-robin search: first valid requester at or above the pointer, wrapping.
   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (PW+1)'(ptr) + (PW+1)'(k);
         if (cand >= (PW+1)'(N_REQ))
            cand = cand - (PW+1)'(N_REQ);
         if (!grant_found && bus.req_valid[cand[PW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[PW-1:0];
         end
      end
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_found)        state_nxt = S_ISSUE;
         S_ISSUE:                         state_nxt = S_WAIT;
         S_WAIT:  if (cnt == '0)          state_nxt = S_RESP;
         S_RESP:  if (bus.rsp_ready[gnt]) state_nxt = S_IDLE;
         default:                         state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs: request accept only in IDLE, response valid only in RESP.
   // req_ready is masked by rst because IDLE is also the state held in reset.
   always_comb begin
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      if (state == S_IDLE && grant_found && !rst)
         bus.req_ready[grant_idx] = 1'b1;
      if (state == S_RESP)
         bus.rsp_valid[gnt] = 1'b1;
   end

   // Datapath: operand latch, ALU drive, latency counter, result capture, pointer.
   // NOTE: the datapath registers are reset too, because the ALU drive and the
   // response data must read zero while in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= '0;
         gnt          <= '0;
         cnt          <= '0;
         lat_sel      <= '0;
         lat_a        <= '0;
         lat_b        <= '0;
         alu_sel      <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         bus.rsp_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  gnt     <= grant_idx;
                  lat_sel <= bus.req_sel[grant_idx*2 +: 2];
                  lat_a   <= bus.req_a[grant_idx*16 +: 16];
                  lat_b   <= bus.req_b[grant_idx*16 +: 16];
               end
            end
            S_ISSUE: begin
               alu_sel <= lat_sel;
               alu_a   <= lat_a;
               alu_b   <= lat_b;
               cnt     <= CW'(ALU_LAT);
            end
            S_WAIT: begin
               // Operands have been stable ALU_LAT cycles once the count hits zero.
               if (cnt == '0)
                  bus.rsp_data <= alu_r;
               else
                  cnt <= cnt - CW'(1);
            end
            S_RESP: begin
               if (bus.rsp_ready[gnt])
                  ptr <= (gnt == PW'(N_REQ - 1)) ? '0 : gnt + PW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a scoreboard of expected responses.
module tb_alu_share_arbiter;

   localparam int N   = 4;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  alu_sel;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [31:0] alu_r;

   logic [1:0]  op_sel [N];
   logic [15:0] op_a   [N];
   logic [15:0] op_b   [N];

   typedef struct {
      int          req;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   order [5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   alu_share_arbiter_if #(.N_REQ(N)) bus ();

   alu_share_arbiter #(.N_REQ(N), .ALU_LAT(LAT)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .alu_sel (alu_sel),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_r   (alu_r)
   );

   function automatic logic [31:0] alu_model(input logic [1:0] s, input logic [15:0] a, input logic [15:0] b);
      case (s)
         2'd0:    return {16'h0, a} + {16'h0, b};
         2'd1:    return {16'h0, a} - {16'h0, b};
         2'd2:    return {16'h0, a} * {16'h0, b};
         default: return {16'h0, a ^ b};
      endcase
   endfunction

   // Stand-in for the shared ALU: one registered stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) alu_r <= '0;
      else     alu_r <= alu_model(alu_sel, alu_a, alu_b);
   end

   // Pack per-requester operands onto the shared buses.
   always_comb begin
      bus.req_sel = '0;
      bus.req_a   = '0;
      bus.req_b   = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_sel[2*i +: 2]  = op_sel[i];
         bus.req_a[16*i +: 16]  = op_a[i];
         bus.req_b[16*i +: 16]  = op_b[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [1:0] s, input logic [15:0] a, input logic [15:0] b);
      op_sel[i] = s;
      op_a[i]   = a;
      op_b[i]   = b;
   endtask

   // Wait (bounded) for a grant, check it, record the expected result, pass the handshake edge.
   task automatic wait_grant(input int exp_g);
      exp_t e;
      int   n = 0;
      #1;
      while (bus.req_ready === '0 && n < 40) begin
         tick();
         n++;
      end
      chk("grant", 32'(bus.req_ready), 32'(1 << exp_g));
      e.req  = exp_g;
      e.data = alu_model(op_sel[exp_g], op_a[exp_g], op_b[exp_g]);
      sb.push_back(e);
      tick();
   endtask

   // Wait (bounded) for a response, compare against the scoreboard, stall hold cycles, complete it.
   task automatic wait_rsp(input int hold);
      exp_t e;
      int   n = 0;
      while (bus.rsp_valid === '0 && n < 40) begin
         tick();
         n++;
      end
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << e.req));
      chk("rsp_data", bus.rsp_data, e.data);
      for (int h = 0; h < hold; h++) begin
         bus.rsp_ready = ~N'(1 << e.req);
         tick();
         chk("hold_valid", 32'(bus.rsp_valid), 32'(1 << e.req));
         chk("hold_data", bus.rsp_data, e.data);
         chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = N'(1 << e.req);
      tick();
      bus.rsp_ready = '0;
      #1;
      chk("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) set_op(i, 2'd0, 16'd0, 16'd0);
      bus.req_valid = '1;
      bus.rsp_ready = '0;

      // Reset state, with all requests asserted to show req_ready is masked.
      #2;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_alu", {14'd0, alu_sel, alu_a}, 32'd0);
      tick();
      tick();
      bus.req_valid = '0;
      rst = 1'b0;
      tick();

      // Single request: exact issue and response timing.
      set_op(0, 2'd0, 16'd10, 16'd20);
      bus.req_valid = 4'b0001;
      #1;
      chk("single_ready", 32'(bus.req_ready), 32'b0001);
      sb.push_back('{req: 0, data: 32'd30});
      tick();
      bus.req_valid = '0;
      tick();
      chk("single_alu_a", 32'(alu_a), 32'd10);
      chk("single_alu_b", 32'(alu_b), 32'd20);
      chk("single_alu_sel", 32'(alu_sel), 32'd0);
      chk("single_rsp_early1", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("single_rsp_early2", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("single_rsp_at_lat", 32'(bus.rsp_valid), 32'b0001);
      wait_rsp(0);

      // Round-robin fairness with all requesters continuously valid.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_op(i, 2'(i), 16'(10 * i), 16'd20);
      bus.req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         wait_grant(order[k]);
         if (k == 4) bus.req_valid = '0;
         wait_rsp(0);
      end

      // Response backpressure on requester 2 with other requests pending.
      set_op(2, 2'd2, 16'd7, 16'd9);
      bus.req_valid = 4'b0100;
      wait_grant(2);
      set_op(0, 2'd0, 16'd100, 16'd5);
      set_op(3, 2'd3, 16'h00F0, 16'h0F0F);
      bus.req_valid = 4'b1001;
      wait_rsp(5);
      chk("bp_next_grant", 32'(bus.req_ready), 32'b1000);
      wait_grant(3);
      bus.req_valid = 4'b0001;
      wait_rsp(0);
      wait_grant(0);
      bus.req_valid = '0;
      wait_rsp(0);

      // Pointer wrap: 3 alone, then 0 and 3 together.
      set_op(3, 2'd2, 16'd300, 16'd3);
      bus.req_valid = 4'b1000;
      wait_grant(3);
      bus.req_valid = '0;
      wait_rsp(0);
      set_op(0, 2'd1, 16'd50, 16'd8);
      set_op(3, 2'd0, 16'hFFFF, 16'h0001);
      bus.req_valid = 4'b1001;
      wait_grant(0);
      bus.req_valid = 4'b1000;
      wait_rsp(0);
      wait_grant(3);
      bus.req_valid = '0;
      wait_rsp(0);

      // Signed result on requester 1.
      set_op(1, 2'd1, 16'd10, 16'd20);
      bus.req_valid = 4'b0010;
      wait_grant(1);
      bus.req_valid = '0;
      for (int n = 0; n < 40 && bus.rsp_valid === '0; n++) tick();
      total++;
      assert ($signed(bus.rsp_data) === -32'sd10) else begin
         bad++;
         $error("FAIL signed_rsp: observed=%0d expected=%0d", $signed(bus.rsp_data), -10);
      end
      wait_rsp(0);

      // Reset during WAIT: pointer is 2 beforehand, the operation is dropped.
      set_op(2, 2'd0, 16'd1000, 16'd2000);
      bus.req_valid = 4'b0100;
      wait_grant(2);
      bus.req_valid = '0;
      tick();
      rst = 1'b1;
      bus.req_valid = 4'b1001;
      #1;
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_rsp_data", bus.rsp_data, 32'd0);
      chk("midrst_alu", {14'd0, alu_sel, alu_a}, 32'd0);
      chk("midrst_alu_b", 32'(alu_b), 32'd0);
      void'(sb.pop_back());
      tick();
      tick();
      bus.req_valid = '0;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("dropped_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      set_op(0, 2'd2, 16'd123, 16'd4);
      set_op(3, 2'd3, 16'hAAAA, 16'h5555);
      bus.req_valid = 4'b1001;
      wait_grant(0);
      bus.req_valid = '0;
      wait_rsp(0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
